// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton synchroniser and debouncer with press, release and long-press events
module button_debounce #(
  parameter int DEBOUNCE_CYCLES   = 540_000,
  parameter int LONG_PRESS_CYCLES = 27_000_000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int CNT_W             = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_btn,
  output logic             o_level,
  output logic             o_press,
  output logic             o_release,
  output logic             o_long_press,
  output logic [CNT_W-1:0] o_press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_d;
  logic [1:0]       sync;
  logic             s;
  logic [DW-1:0]    deb_cnt, deb_d;
  logic [HW-1:0]    hold_cnt, hold_d;
  logic             long_done, long_done_d;
  logic             level_d, press_d, release_d, long_d;
  logic [CNT_W-1:0] count_d;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{ACTIVE_LOW}};
    end else begin
      sync <= {sync[0], i_btn};
    end
  end

  assign s = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      o_level       <= 1'b0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
      o_long_press  <= 1'b0;
      o_press_count <= '0;
    end else begin
      state         <= state_d;
      deb_cnt       <= deb_d;
      hold_cnt      <= hold_d;
      long_done     <= long_done_d;
      o_level       <= level_d;
      o_press       <= press_d;
      o_release     <= release_d;
      o_long_press  <= long_d;
      o_press_count <= count_d;
    end
  end

  always_comb begin
    state_d     = state;
    deb_d       = deb_cnt;
    hold_d      = hold_cnt;
    long_done_d = long_done;
    level_d     = o_level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    count_d     = o_press_count;

    // Hold time keeps running through release bounces; long_done limits it to one pulse per press.
    if (state == PRESSED || state == RELEASE_WAIT) begin
      if (hold_cnt == HOLD_LAST) begin
        if (!long_done) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        hold_d = hold_cnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          press_d     = 1'b1;
          count_d     = o_press_count + 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          deb_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

  logic       clk;
  logic       rst_n;
  logic       i_btn;
  logic       o_level;
  logic       o_press;
  logic       o_release;
  logic       o_long_press;
  logic [3:0] o_press_count;

  int tests_run;
  int tests_failed;

  // Event monitor state, cleared per scenario; times are ticks since the clear.
  int tcur;
  int n_press, n_rel, n_long, overlap;
  int t_press, t_rel, t_long;

  button_debounce #(
    .DEBOUNCE_CYCLES  (8),
    .LONG_PRESS_CYCLES(40),
    .ACTIVE_LOW       (1'b1),
    .CNT_W            (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_btn        (i_btn),
    .o_level      (o_level),
    .o_press      (o_press),
    .o_release    (o_release),
    .o_long_press (o_long_press),
    .o_press_count(o_press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mon();
    tcur    = 0;
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
    overlap = 0;
    t_press = -1;
    t_rel   = -1;
    t_long  = -1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tcur++;
      if (o_press) begin
        n_press++;
        if (t_press < 0) t_press = tcur;
      end
      if (o_release) begin
        n_rel++;
        if (t_rel < 0) t_rel = tcur;
      end
      if (o_long_press) begin
        n_long++;
        if (t_long < 0) t_long = tcur;
      end
      if (o_press && o_release) overlap++;
    end
  endtask

  task automatic test_reset();
    i_btn = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_level, o_press, o_release, o_long_press, o_press_count} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {o_level, o_press, o_release, o_long_press, o_press_count});
    end
    run_cycles(3);
    rst_n = 1'b1;
    clear_mon();
    run_cycles(50);
    tests_run++;
    if (n_press + n_rel + n_long !== 0) begin
      tests_failed++;
      $display("FAIL idle_no_events: got %0d events, expected 0", n_press + n_rel + n_long);
    end
    tests_run++;
    if ({o_level, o_press_count} !== 5'b0) begin
      tests_failed++;
      $display("FAIL idle_level_count: got level=%b count=%0d, expected 0/0", o_level, o_press_count);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    for (int g = 0; g < 10; g++) begin
      i_btn = 1'b0;
      run_cycles(3);
      i_btn = 1'b1;
      run_cycles(3);
    end
    run_cycles(20);
    tests_run++;
    if (n_press !== 0) begin
      tests_failed++;
      $display("FAIL glitch_press: got %0d presses, expected 0", n_press);
    end
    tests_run++;
    if (o_level !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_level: got %b, expected 0", o_level);
    end
    tests_run++;
    if (o_press_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL glitch_count: got %0d, expected 0", o_press_count);
    end
  endtask

  task automatic test_press_long();
    clear_mon();
    i_btn = 1'b0;
    run_cycles(70);
    tests_run++;
    if (n_press !== 1) begin
      tests_failed++;
      $display("FAIL press_once: got %0d presses, expected 1", n_press);
    end
    tests_run++;
    if (!(t_press >= 9 && t_press <= 11)) begin
      tests_failed++;
      $display("FAIL press_latency: got %0d cycles, expected 9..11", t_press);
    end
    tests_run++;
    if (o_level !== 1'b1 || o_press_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL press_state: got level=%b count=%0d, expected 1/1", o_level, o_press_count);
    end
    tests_run++;
    if (n_long !== 1) begin
      tests_failed++;
      $display("FAIL long_once: got %0d pulses, expected 1", n_long);
    end
    tests_run++;
    if (t_long - t_press !== 40) begin
      tests_failed++;
      $display("FAIL long_delay: got %0d cycles after press, expected 40", t_long - t_press);
    end
    clear_mon();
    i_btn = 1'b1;
    run_cycles(20);
    tests_run++;
    if (n_rel !== 1 || !(t_rel >= 9 && t_rel <= 11)) begin
      tests_failed++;
      $display("FAIL release_latency: got %0d pulses at cycle %0d, expected 1 at 9..11", n_rel, t_rel);
    end
    tests_run++;
    if (o_level !== 1'b0 || n_long !== 0) begin
      tests_failed++;
      $display("FAIL release_state: got level=%b long=%0d, expected 0/0", o_level, n_long);
    end
  endtask

  task automatic test_bounce();
    clear_mon();
    i_btn = 1'b0;
    run_cycles(20);
    for (int b = 0; b < 2; b++) begin
      i_btn = 1'b1;
      run_cycles(2);
      i_btn = 1'b0;
      run_cycles(2);
    end
    i_btn = 1'b1;
    run_cycles(20);
    tests_run++;
    if (n_press !== 1 || n_rel !== 1) begin
      tests_failed++;
      $display("FAIL bounce_events: got press=%0d release=%0d, expected 1/1", n_press, n_rel);
    end
    tests_run++;
    if (n_long !== 0) begin
      tests_failed++;
      $display("FAIL bounce_long: got %0d, expected 0", n_long);
    end
    tests_run++;
    if (o_level !== 1'b0 || o_press_count !== 4'd2) begin
      tests_failed++;
      $display("FAIL bounce_state: got level=%b count=%0d, expected 0/2", o_level, o_press_count);
    end
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++;
      $display("FAIL bounce_overlap: got %0d, expected 0", overlap);
    end
  endtask

  task automatic test_wrap_reset();
    i_btn = 1'b1;
    rst_n = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
    clear_mon();
    for (int p = 0; p < 16; p++) begin
      i_btn = 1'b0;
      run_cycles(15);
      i_btn = 1'b1;
      run_cycles(15);
      if (p == 14) begin
        tests_run++;
        if (o_press_count !== 4'd15) begin
          tests_failed++;
          $display("FAIL count_15: got %0d, expected 15", o_press_count);
        end
      end
    end
    tests_run++;
    if (o_press_count !== 4'd0 || n_press !== 16 || n_rel !== 16) begin
      tests_failed++;
      $display("FAIL count_wrap: got count=%0d press=%0d release=%0d, expected 0/16/16",
               o_press_count, n_press, n_rel);
    end
    i_btn = 1'b0;
    run_cycles(15);
    tests_run++;
    if (o_level !== 1'b1) begin
      tests_failed++;
      $display("FAIL held_level: got %b, expected 1", o_level);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_level, o_press, o_release, o_long_press, o_press_count} !== 8'h00) begin
      tests_failed++;
      $display("FAIL midpress_reset: got %b, expected 00000000",
               {o_level, o_press, o_release, o_long_press, o_press_count});
    end
    run_cycles(2);
    rst_n = 1'b1;
    clear_mon();
    run_cycles(20);
    tests_run++;
    if (n_press !== 1 || !(t_press >= 9 && t_press <= 11)) begin
      tests_failed++;
      $display("FAIL repress_after_reset: got %0d presses at cycle %0d, expected 1 at 9..11",
               n_press, t_press);
    end
    tests_run++;
    if (o_press_count !== 4'd1 || o_level !== 1'b1) begin
      tests_failed++;
      $display("FAIL repress_state: got count=%0d level=%b, expected 1/1", o_press_count, o_level);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_btn        = 1'b1;
    rst_n        = 1'b0;
    clear_mon();
    test_reset();
    test_glitch();
    test_press_long();
    test_bounce();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
